// File: rtl/gray_pkg.sv
// Shared definitions for the Gray-code blocks: the default word width and
// the state encoding of the serial decoder.
package gray_pkg;

  localparam int GRAY_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    DONE   = 2'd2
  } state_e;

endpackage

// File: rtl/gray_to_binary_serial.sv
// Serial Gray-to-binary decoder. It accepts one Gray word, resolves one bit
// per clock from MSB to LSB, and holds the result until it is consumed.
module gray_to_binary_serial
  import gray_pkg::*;
#(
  parameter int WIDTH = GRAY_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] gray,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] binary,
  output logic             busy
);

  localparam int IDX_W = $clog2(WIDTH);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   g_q, g_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  // acc_q carries res[idx+1], the previously resolved bit (0 above the MSB).
  logic               acc_q, acc_d;
  logic               bit_d;

  // NOTE: every signal assigned in always_comb gets its default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    res_d   = res_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    bit_d   = g_q[idx_q] ^ acc_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          g_d     = gray;
          res_d   = '0;
          idx_d   = IDX_W'(WIDTH - 1);
          acc_d   = 1'b0;
          state_d = DECODE;
        end
      end
      DECODE: begin
        res_d[idx_q] = bit_d;
        acc_d        = bit_d;
        if (idx_q == '0) begin
          state_d = DONE;
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: registers use non-blocking assignments so every flop samples the pre-edge values computed above.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      g_q     <= '0;
      res_q   <= '0;
      idx_q   <= '0;
      acc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      res_q   <= res_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign binary    = res_q;

endmodule

// File: doc/gray_to_binary_serial.md
# gray_to_binary_serial

Sequential Gray-to-binary decoder, the inverse of the team's combinational binary-to-Gray converter. It accepts one WIDTH-bit Gray word through a valid/ready handshake and decodes it MSB-first, one bit per clock. It presents the binary result on a valid/ready output port and holds it until the result is consumed. It sits on the receive side of Gray-coded paths (counter pointers, encoder outputs), where area matters more than throughput.

## Interface
- WIDTH, 8, word width in bits; legal range 2..32.
- clk  input  1  sole clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous and active-high.
- in_valid  input  1  upstream presents a Gray word on gray.
- in_ready  output  1  block can accept a word; high only in IDLE.
- gray  input  WIDTH  Gray-coded word; sampled only on an input handshake.
- out_valid  output  1  binary holds a complete decoded result.
- out_ready  input  1  downstream accepts the result.
- binary  output  WIDTH  decoded binary word; meaningful only while out_valid=1.
- busy  output  1  high in DECODE or DONE.

## Operation
- FSM states: IDLE, DECODE, DONE. All outputs are derived from registers or state; there is no input-to-output combinational path.
- IDLE: in_ready=1.
  - On in_valid&&in_ready: capture gray into g_reg, clear the result register, set idx=WIDTH-1, go to DECODE.
  - With in_valid=0, stay in IDLE.
- DECODE: each cycle computes res[idx] = g_reg[idx] ^ res[idx+1], with res[WIDTH] treated as 0.
  - If idx=0, go to DONE. Otherwise idx decrements.
  - in_ready=0. in_valid is ignored.
- DONE: out_valid=1. binary=res, held stable until the output handshake.
  - On out_valid&&out_ready, go to IDLE.
  - If out_ready=0, stay in DONE with no change to any output.
- After the handshake, binary keeps its last value until the next accept clears it. It is unqualified while out_valid=0.
- idx counter width is $clog2(WIDTH). It never wraps below 0, because the DONE transition is taken at idx=0.
- Result identity: binary[i] = XOR of gray[WIDTH-1:i].
- Reset: state=IDLE, g_reg=0, res=0, idx=0. Outputs after reset: in_ready=1, out_valid=0, binary=0, busy=0.
- Reset mid-operation (DECODE or DONE): the in-flight word is discarded, no out_valid is produced, and the block returns to IDLE on the next edge.
- rst has priority over any handshake occurring in the same cycle.

## Timing
- Accept edge E0: IDLE to DECODE.
- Decode edges E1..E(WIDTH): bits MSB to LSB.
- out_valid rises after edge E(WIDTH). Latency is WIDTH cycles from accept to out_valid.
- With out_ready held at 1, the output handshake occurs at E(WIDTH+1). in_ready is high in the following cycle, so the next accept can occur at E(WIDTH+2).
- Maximum throughput: one word per WIDTH+2 cycles (10 for WIDTH=8).
- An input word arriving while the block is busy is not lost. Upstream must hold in_valid and gray stable until in_ready.

## Structure
- Shared package gray_pkg holds:
  - the state encoding constants (IDLE=2'd0, DECODE=2'd1, DONE=2'd2);
  - the default width GRAY_WIDTH=8.
- Shared with the binary-to-Gray converter's bench, so both sides agree on the default width.
- Single module; no sub-module is warranted. The per-bit XOR step is one expression inside the FSM.
- The bench instantiates the existing binary-to-Gray converter as the stimulus generator and reference.

## Test plan
- Reset: hold rst for 2 cycles, then release. Required: in_ready=1, out_valid=0, binary=8'h00, busy=0.
- Known vectors, WIDTH=8:
  - gray 8'h00 gives binary 8'h00;
  - gray 8'hC0 gives 8'h80;
  - gray 8'h80 gives 8'hFF;
  - gray 8'h01 gives 8'h01.
- Latency: accept at edge E0. Required: out_valid=0 through E7 and out_valid=1 exactly after E8; in_ready=0 from E0 until the output handshake.
- Backpressure: gray 8'h5A, out_ready=0 for 5 cycles after out_valid rises, in_valid=1 with gray 8'hFF throughout. Required: binary stays 8'h6C, out_valid stays 1, in_ready stays 0, and 8'hFF is accepted only after out_ready=1.
- Reset mid-decode: assert rst for 1 cycle at E3 after accepting 8'hAA. Required: out_valid never rises; in_ready=1 and binary=0 on the next cycle.
- Exhaustive: convert binary 0..255 to Gray through the encoder and stream the results back-to-back with out_ready=1. Required: every binary output equals the original value, with one result every 10 cycles.
